// File: rtl/ones_count_pkg.sv
// Shared definitions for the streaming ones counter.
// Contents: the state encoding, the width helpers used to derive the counter widths,
// and a saturating adder that the accumulator and the word counter both use.
package ones_count_pkg;

  // State encoding. DRAIN is reached only when ONES_STREAM_PIPE_EN is defined.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACC   = ST_ACC,
    DRAIN = ST_DRAIN,
    HOLD  = ST_HOLD
  } state_t;

  // Ceiling log2. Returns 0 for v <= 1. Used only in constant contexts.
  function automatic int clog2_u(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: enough for a full nominal frame of all-ones words.
  function automatic int cnt_width(input int data_w, input int max_words);
    return clog2_u(data_w * max_words + 1);
  endfunction

  // Word-counter width: enough to hold MAX_WORDS.
  function automatic int word_width(input int max_words);
    return clog2_u(max_words + 1);
  endfunction

  // a + b clamped to max. Operands are zero-extended to 32 bits by the caller
  // and the result is narrowed back, so one function serves every counter width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/ones_count_stream_popcount.sv
// popcount_w: purely combinational count of the set bits in one DATA_W-bit word.
// This is the width-generic form of the original 8-bit ones counter.
module popcount_w #(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  // Ripple sum of every bit; synthesis turns this into an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/ones_count_stream.sv
// ones_count_stream: counts set bits across a frame of DATA_W-bit words received on a
// valid/ready stream and emits one result per frame (ones total, word count, overflow).
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are both high.
// The producer must hold valid and its payload until that edge; the consumer's ready
// may change freely and never depends on the same interface's valid.
//
// Configuration macro: ONES_STREAM_PIPE_EN
//   undefined - popcount feeds the accumulator directly; out_valid rises one cycle
//               after the last word is accepted.
//   defined   - popcount and in_last are registered first; a DRAIN state covers the
//               extra stage, so out_valid rises two cycles after the last word and
//               in_ready drops one cycle after it. Throughput stays one word per cycle.
module ones_count_stream
  import ones_count_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int MAX_WORDS = 16,
  localparam int CNT_W     = cnt_width(DATA_W, MAX_WORDS),
  localparam int WORD_W    = word_width(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [WORD_W-1:0] out_words,
  output logic              out_ovf
);

  localparam int          PC_W     = $clog2(DATA_W + 1);
  localparam logic [31:0] CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0] WORD_MAX = 32'((64'd1 << WORD_W) - 64'd1);

`ifdef ONES_STREAM_PIPE_EN
  // With the extra stage the last word still has to drain before the result exists.
  localparam state_t LAST_DEST = DRAIN;
`else
  localparam state_t LAST_DEST = HOLD;
`endif

  state_t             state;
  logic [CNT_W-1:0]   acc;
  logic [WORD_W-1:0]  wcnt;
  logic               ovf;

  logic               in_xfer;
  logic               out_xfer;
  logic [PC_W-1:0]    word_ones;

  // Word presented to the accumulator this cycle.
  logic               add_en;
  logic               add_last;
  logic [PC_W-1:0]    add_ones;

  logic [CNT_W-1:0]   acc_next;
  logic [WORD_W-1:0]  wcnt_next;
  logic               ovf_next;

  popcount_w #(.DATA_W(DATA_W)) u_popcount (
    .data  (in_data),
    .count (word_ones)
  );

  // Words are taken only while a frame is open; reset overrides everything.
  assign in_ready = !rst && ((state == IDLE) || (state == ACC));
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef ONES_STREAM_PIPE_EN
  logic            stg_valid;
  logic            stg_last;
  logic [PC_W-1:0] stg_ones;

  // Register the per-word bit count and the frame marker ahead of the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_last  <= 1'b0;
      stg_ones  <= '0;
    end else begin
      stg_valid <= in_xfer;
      stg_last  <= in_xfer && in_last;
      stg_ones  <= word_ones;
    end
  end

  assign add_en   = stg_valid;
  assign add_last = stg_last;
  assign add_ones = stg_ones;
`else
  assign add_en   = in_xfer;
  assign add_last = in_last;
  assign add_ones = word_ones;
`endif

  // Next accumulator values. Both counters clamp at all-ones. The overflow flag is
  // sticky and is set by any word arriving once MAX_WORDS words are already counted,
  // so it stays correct even when the word counter itself has saturated.
  always_comb begin
    acc_next  = CNT_W'(sat_add(32'(acc), 32'(add_ones), CNT_MAX));
    wcnt_next = WORD_W'(sat_add(32'(wcnt), 32'd1, WORD_MAX));
    ovf_next  = ovf || (32'(wcnt) >= 32'(MAX_WORDS));
  end

  // Frame FSM together with the accumulator and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      wcnt      <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_words <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (in_xfer) state <= in_last ? LAST_DEST : ACC;
        end
        DRAIN: begin
          if (add_en && add_last) state <= HOLD;
        end
        HOLD: begin
          if (out_xfer) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // The accumulator never sees a word while a result is held, so the
      // two branches below never compete for the same cycle.
      if (add_en) begin
        acc  <= acc_next;
        wcnt <= wcnt_next;
        ovf  <= ovf_next;
        if (add_last) begin
          out_valid <= 1'b1;
          out_count <= acc_next;
          out_words <= wcnt_next;
          out_ovf   <= ovf_next;
        end
      end else if (out_xfer) begin
        // Result consumed: start the next frame from zero.
        out_valid <= 1'b0;
        acc       <= '0;
        wcnt      <= '0;
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ones_count_stream.sv
// Bench for ones_count_stream (DATA_W=8, MAX_WORDS=16). Works with or without
// ONES_STREAM_PIPE_EN; only the expected latency changes.
module tb_ones_count_stream;

  localparam int DATA_W    = 8;
  localparam int MAX_WORDS = 16;
  localparam int CNT_W     = $clog2(DATA_W * MAX_WORDS + 1);
  localparam int WORD_W    = $clog2(MAX_WORDS + 1);
  localparam int RES_W     = CNT_W + WORD_W + 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int WORD_MAX  = (1 << WORD_W) - 1;
`ifdef ONES_STREAM_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [WORD_W-1:0] out_words;
  logic              out_ovf;

  ones_count_stream #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_words (out_words),
    .out_ovf   (out_ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [RES_W-1:0] exp_q[$];
  int               lat_q[$];

  // Reference model: frame totals kept as plain integers, clamped only when reported.
  int ones_acc  = 0;
  int words_acc = 0;

  bit stall    = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_word(input logic [DATA_W-1:0] d, input bit last);
    int c, w;
    ones_acc  += $countones(d);
    words_acc += 1;
    if (last) begin
      c = (ones_acc > CNT_MAX) ? CNT_MAX : ones_acc;
      w = (words_acc > WORD_MAX) ? WORD_MAX : words_acc;
      exp_q.push_back({CNT_W'(c), WORD_W'(w), (words_acc > MAX_WORDS)});
      ones_acc  = 0;
      words_acc = 0;
    end
  endtask

  // ---------------- driver tasks (call at a negedge, return at a negedge) ----------------
  task automatic send_word(input logic [DATA_W-1:0] d, input bit last, input bit gap);
    int waited;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, data=%0h", waited, d);
      in_valid = 1'b0;
      return;
    end
    // The word transfers on the coming posedge.
    model_word(d, last);
    if (last) lat_q.push_back(cyc + LAT);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_word(d, (i == n - 1), gaps && ($urandom_range(0, 3) == 0));
    end
  endtask

  // ---------------- output-ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = stall ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit               prev_valid;
    bit               prev_ready;
    logic [RES_W-1:0] held;
    logic [RES_W-1:0] exp;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (out_valid) begin
        check("in_ready_while_holding", in_ready, 1'b0);
        if (prev_valid && !prev_ready)
          check("result_stable", {out_count, out_words, out_ovf}, held);
        if (!prev_valid) begin
          if (lat_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL latency: out_valid rose at cycle %0d with no frame pending", cyc);
          end else begin
            check("latency", cyc, lat_q.pop_front());
          end
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_result: count=%0d words=%0d ovf=%0b",
                     out_count, out_words, out_ovf);
          end else begin
            exp = exp_q.pop_front();
            check("out_count", out_count, exp[RES_W-1 -: CNT_W]);
            check("out_words", out_words, exp[WORD_W:1]);
            check("out_ovf",   out_ovf,   exp[0]);
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      held       = {out_count, out_words, out_ovf};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_count", out_count, '0);
    check("reset_out_words", out_words, '0);
    check("reset_out_ovf",   out_ovf,   1'b0);
    check("reset_in_ready",  in_ready,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // 1. Single-word frames covering every byte value.
    rand_rdy = 1'b1;
    for (int v = 0; v < 256; v++) send_word(8'(v), 1'b1, 1'b0);

    // 2. Short multi-word frame.
    rand_rdy = 1'b0;
    send_word(8'h01, 1'b0, 1'b0);
    send_word(8'h03, 1'b0, 1'b0);
    send_word(8'h07, 1'b1, 1'b0);

    // 3. Output stalled with the next word already waiting.
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    send_word(8'h3C, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_last  = 1'b1;
    waited   = 0;
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("stall_out_valid_seen", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
    end
    stall = 1'b0;
    send_word(8'h81, 1'b1, 1'b0);

    // 4. Overlong frames: past MAX_WORDS, then into saturation.
    send_frame(8'hFF, 18, 1'b0);
    send_frame(8'hFF, 40, 1'b0);

    // 5. Reset in the middle of a frame.
    send_word(8'hFF, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0);
    rst       = 1'b1;
    ones_acc  = 0;
    words_acc = 0;
    #1;
    check("midreset_in_ready",  in_ready,  1'b0);
    check("midreset_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check("midreset_out_valid_2", out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    send_word(8'h0F, 1'b1, 1'b0);

    // 6. Back-to-back frames.
    send_word(8'h00, 1'b1, 1'b0);
    send_word(8'hAA, 1'b0, 1'b0);
    send_word(8'h55, 1'b1, 1'b0);

    // Random frames with random gaps and random back-pressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++)
        send_word(8'($urandom), (i == n - 1), ($urandom_range(0, 3) == 0));
    end

    // Drain the scoreboard.
    rand_rdy = 1'b0;
    waited   = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("latency_queue_drained", lat_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
